// File: rtl/dma_engine.sv
// dma_engine: single-channel memory-to-memory byte copier.
//
// The core programs source, destination and size through byte registers
// decoded from auxdaddr. A write lands on every edge where the address
// matches, with no separate strobe. START launches a copy. The engine then
// owns the external RAM port and alternates READ/WRITE, one byte per
// two cycles. It raises irq in DONE and waits there for ack.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   auxdaddr      core address, register decode (0x0100..0x0105)
//   auxdin        core write data
//   extdout       RAM read data, one cycle after the address
//   ack           interrupt acknowledge (honoured only in DONE)
//   irq           transfer complete
//   auxdoutsel    1 while the engine owns the RAM port
//   extdin        RAM write data
//   extdaddr      RAM address
//   extwe         RAM write enable
//   state         debug: FSM state code
//   counter       debug: bytes already copied
//   numbytes      debug: total bytes, (N+1) << SHIFT
module dma_engine #(
  parameter int SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] auxdaddr,
  input  logic [7:0]  auxdin,
  input  logic [7:0]  extdout,
  input  logic        ack,
  output logic        irq,
  output logic        auxdoutsel,
  output logic [7:0]  extdin,
  output logic [15:0] extdaddr,
  output logic        extwe,
  output logic [2:0]  state,
  output logic [15:0] counter,
  output logic [15:0] numbytes
);

  localparam logic [15:0] A_START = 16'h0100;
  localparam logic [15:0] A_SRC_L = 16'h0101;
  localparam logic [15:0] A_SRC_H = 16'h0102;
  localparam logic [15:0] A_DST_L = 16'h0103;
  localparam logic [15:0] A_DST_H = 16'h0104;
  localparam logic [15:0] A_N     = 16'h0105;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t      cur, nxt;
  logic [15:0] src, dst;
  logic [7:0]  n;
  logic        start_hit;
  logic        last_byte;

  assign start_hit = (auxdaddr == A_START);
  // N is at most 255 and SHIFT at most 7, so the 16-bit result never overflows.
  assign numbytes  = ({8'b0, n} + 16'd1) << SHIFT;
  assign last_byte = ((counter + 16'd1) == numbytes);
  assign state     = cur;

  always_ff @(posedge clk) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  // Configuration is frozen outside IDLE, so a transfer cannot be disturbed
  // by the core scribbling on the register window.
  always_ff @(posedge clk) begin
    if (rst) begin
      src     <= '0;
      dst     <= '0;
      n       <= '0;
      counter <= '0;
    end else begin
      if (cur == S_IDLE) begin
        case (auxdaddr)
          A_SRC_L: src[7:0]  <= auxdin;
          A_SRC_H: src[15:8] <= auxdin;
          A_DST_L: dst[7:0]  <= auxdin;
          A_DST_H: dst[15:8] <= auxdin;
          A_N:     n         <= auxdin;
          A_START: counter   <= '0;
          default: ;
        endcase
      end
      if (cur == S_WRITE) counter <= counter + 16'd1;
    end
  end

  always_comb begin
    nxt        = cur;
    irq        = 1'b0;
    auxdoutsel = 1'b0;
    extwe      = 1'b0;
    extdaddr   = '0;
    extdin     = '0;
    case (cur)
      S_IDLE: begin
        if (start_hit) nxt = S_READ;
      end
      S_READ: begin
        auxdoutsel = 1'b1;
        extdaddr   = src + counter;
        nxt        = S_WRITE;
      end
      S_WRITE: begin
        // Read data from the previous cycle's address goes straight back out.
        auxdoutsel = 1'b1;
        extwe      = 1'b1;
        extdaddr   = dst + counter;
        extdin     = extdout;
        nxt        = last_byte ? S_DONE : S_READ;
      end
      S_DONE: begin
        irq = 1'b1;
        if (ack) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_engine.sv
module tb_dma_engine;
  localparam int SHIFT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] auxdaddr = '0;
  logic [7:0]  auxdin = '0;
  logic [7:0]  extdout = '0;
  logic        ack = 1'b0;
  logic        irq, auxdoutsel, extwe;
  logic [7:0]  extdin;
  logic [15:0] extdaddr;
  logic [2:0]  state;
  logic [15:0] counter, numbytes;

  dma_engine #(.SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .auxdaddr(auxdaddr), .auxdin(auxdin),
    .extdout(extdout), .ack(ack), .irq(irq), .auxdoutsel(auxdoutsel),
    .extdin(extdin), .extdaddr(extdaddr), .extwe(extwe), .state(state),
    .counter(counter), .numbytes(numbytes)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // External RAM: synchronous read, one cycle latency.
  logic [7:0] ram [0:65535];
  int wr_cnt = 0;
  always @(posedge clk) begin
    extdout <= ram[extdaddr];
    if (extwe === 1'b1) begin
      ram[extdaddr] <= extdin;
      wr_cnt++;
    end
  end

  // Reference model: a transfer is a timeline t = 1..2*nb after the START
  // edge; odd t reads byte (t-1)/2, even t writes it. After that it sits
  // done until ack. exp_mem is the memory as the copy should leave it.
  logic [7:0]  exp_mem [0:65535];
  bit          m_valid = 0;
  int          m_mode = 0;        // 0 idle, 1 copying, 2 done
  int          m_t = 0;
  logic [15:0] m_src = 0, m_dst = 0, m_cnt = 0;
  logic [7:0]  m_n = 0;
  int          e = 0;             // edge counter

  function automatic int m_nb();
    return (int'(m_n) + 1) << SHIFT;
  endfunction

  always @(posedge clk) begin
    logic [15:0] i;
    e++;
    if (m_mode == 1 && (m_t % 2) == 0) begin
      i = 16'((m_t - 1) / 2);
      exp_mem[16'(m_dst + i)] = exp_mem[16'(m_src + i)];
    end
    if (rst) begin
      m_valid = 1; m_mode = 0; m_t = 0;
      m_src = 0; m_dst = 0; m_n = 0; m_cnt = 0;
    end else if (m_valid) begin
      case (m_mode)
        0: case (auxdaddr)
             16'h0100: begin m_mode = 1; m_t = 1; m_cnt = 0; end
             16'h0101: m_src[7:0]  = auxdin;
             16'h0102: m_src[15:8] = auxdin;
             16'h0103: m_dst[7:0]  = auxdin;
             16'h0104: m_dst[15:8] = auxdin;
             16'h0105: m_n         = auxdin;
             default: ;
           endcase
        1: if (m_t == 2 * m_nb()) begin m_mode = 2; m_cnt = 16'(m_nb()); end
           else m_t++;
        default: if (ack) m_mode = 0;
      endcase
    end
  end

  logic [15:0] rd_q[$];
  logic [15:0] wa_q[$];

  always @(negedge clk) begin
    logic [2:0]  es;
    logic        ei, esel, ewe;
    logic [15:0] ea, ec, i;
    logic [7:0]  ed;
    if (m_valid) begin
      es = 0; ei = 0; esel = 0; ewe = 0; ea = 0; ed = 0; ec = m_cnt;
      if (m_mode == 1) begin
        i = 16'((m_t - 1) / 2);
        esel = 1; ec = i;
        if (m_t % 2 == 1) begin
          es = 1; ea = m_src + i;
        end else begin
          es = 2; ea = m_dst + i; ewe = 1; ed = exp_mem[16'(m_src + i)];
        end
      end else if (m_mode == 2) begin
        es = 3; ei = 1;
      end
      chk("outputs", {2'b0, state, irq, auxdoutsel, extwe, extdaddr, extdin, counter, numbytes},
          {2'b0, es, ei, esel, ewe, ea, ed, ec, 16'(m_nb())});
      if (state == 3'd1) rd_q.push_back(extdaddr);
      if (extwe === 1'b1) wa_q.push_back(extdaddr);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    auxdaddr = a; auxdin = d; cyc(); auxdaddr = 0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    ram[a] = d; exp_mem[a] = d;
  endtask

  task automatic cfg(input logic [15:0] s, input logic [15:0] d, input logic [7:0] nn);
    wr(16'h0101, s[7:0]); wr(16'h0102, s[15:8]);
    wr(16'h0103, d[7:0]); wr(16'h0104, d[15:8]);
    wr(16'h0105, nn);
  endtask

  // START for one edge; returns that edge's index.
  task automatic start(output int k);
    auxdaddr = 16'h0100; cyc(); k = e; auxdaddr = 0;
  endtask

  // Runs until irq, optionally throwing random bus traffic at the engine.
  task automatic wait_irq(input bit noise, output int at);
    at = -1;
    for (int c = 0; c < 3000; c++) begin
      if (irq === 1'b1) begin at = e; break; end
      if (noise) begin
        auxdaddr = ($urandom_range(0, 1) == 1) ? 16'(16'h0100 + $urandom_range(0, 5))
                                              : 16'($urandom);
        auxdin = 8'($urandom);
      end
      cyc();
    end
    auxdaddr = 0;
    if (at < 0) chk("irq_timeout", 0, 1);
  endtask

  task automatic ack_pulse();
    ack = 1; cyc(); ack = 0;
  endtask

  initial begin
    int k, at, base;
    logic [7:0] keep;
    logic [15:0] s, d;
    logic [7:0] nn;
    logic [15:0] exp_rd [4];
    logic [15:0] exp_wa [4];

    for (int j = 0; j < 65536; j++) begin
      ram[j] = 8'($urandom);
      exp_mem[j] = ram[j];
    end

    // Reset
    rst = 1; cyc(); cyc(); rst = 0;
    chk("rst_state", state, 0);
    chk("rst_numbytes", numbytes, 4);
    chk("rst_irq_we_sel", {irq, extwe, auxdoutsel}, 0);

    // Basic copy: 16 bytes, 0x0020 -> 0x0030
    for (int j = 0; j < 16; j++) poke(16'(16'h0020 + j), 8'(8'h10 - j));
    cfg(16'h0020, 16'h0030, 8'h03);
    chk("basic_numbytes", numbytes, 16);
    start(k);
    wait_irq(0, at);
    chk("basic_irq_cycle", (at + 1) - k, 33);
    chk("basic_counter", counter, 16);
    for (int j = 0; j < 16; j++) chk("basic_dst", ram[16'(16'h0030 + j)], 8'(8'h10 - j));

    // Interrupt handshake: DONE holds with no writes until ack.
    base = wr_cnt;
    for (int j = 0; j < 10; j++) cyc();
    chk("hold_irq", irq, 1);
    chk("hold_no_writes", wr_cnt - base, 0);
    ack_pulse();
    chk("ack_irq", irq, 0);
    chk("ack_state", state, 0);

    // Minimum size, and START together with ack in DONE.
    poke(16'h0054, 8'hA5);
    cfg(16'h0040, 16'h0050, 8'h00);
    base = wr_cnt;
    start(k);
    wait_irq(0, at);
    chk("min_writes", wr_cnt - base, 4);
    chk("min_after_block", ram[16'h0054], 8'hA5);
    auxdaddr = 16'h0100; ack = 1; cyc(); auxdaddr = 0; ack = 0;
    chk("start_ack_state", state, 0);
    cyc();
    chk("start_ack_idle", state, 0);

    // Busy lockout: register writes and repeated START during a transfer.
    cfg(16'h0060, 16'h0070, 8'h01);
    auxdaddr = 16'h0100; cyc(); cyc(); cyc();
    auxdaddr = 16'h0105; auxdin = 8'hFF; cyc();
    auxdaddr = 16'h0101; auxdin = 8'h00; cyc();
    auxdaddr = 16'h0100; cyc(); auxdaddr = 0;
    chk("lock_numbytes", numbytes, 8);
    wait_irq(0, at);
    chk("lock_counter", counter, 8);
    for (int j = 0; j < 8; j++)
      chk("lock_dst", ram[16'(16'h0070 + j)], exp_mem[16'(16'h0060 + j)]);
    ack_pulse();

    // Address wrap on both sides.
    cfg(16'hFFFE, 16'h00FE, 8'h00);
    rd_q.delete(); wa_q.delete();
    start(k);
    wait_irq(0, at);
    exp_rd = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_wa = '{16'h00FE, 16'h00FF, 16'h0100, 16'h0101};
    chk("wrap_nreads", rd_q.size(), 4);
    chk("wrap_nwrites", wa_q.size(), 4);
    for (int j = 0; j < 4 && j < rd_q.size(); j++) chk("wrap_rd", rd_q[j], exp_rd[j]);
    for (int j = 0; j < 4 && j < wa_q.size(); j++) chk("wrap_wa", wa_q[j], exp_wa[j]);
    ack_pulse();

    // Reset after three bytes.
    cfg(16'h0200, 16'h0300, 8'h03);
    keep = ram[16'h0303];
    base = wr_cnt;
    start(k);
    for (int c = 0; c < 100 && (wr_cnt - base) < 3; c++) cyc();
    rst = 1; cyc(); rst = 0;
    chk("rmid_state", state, 0);
    chk("rmid_we_irq_sel", {extwe, irq, auxdoutsel}, 0);
    chk("rmid_counter", counter, 0);
    chk("rmid_numbytes", numbytes, 4);
    for (int j = 0; j < 5; j++) cyc();
    chk("rmid_writes", wr_cnt - base, 3);
    chk("rmid_4th_byte", ram[16'h0303], keep);

    // Random transfers with bus noise during the copy.
    for (int r = 0; r < 8; r++) begin
      s = 16'($urandom); d = 16'($urandom); nn = 8'($urandom_range(0, 7));
      cfg(s, d, nn);
      base = wr_cnt;
      start(k);
      wait_irq(1, at);
      chk("rnd_latency", at - k, 2 * ((int'(nn) + 1) << SHIFT));
      chk("rnd_writes", wr_cnt - base, (int'(nn) + 1) << SHIFT);
      for (int j = 0; j < ((int'(nn) + 1) << SHIFT); j++)
        chk("rnd_dst", ram[16'(d + j)], exp_mem[16'(d + j)]);
      for (int j = 0; j < int'($urandom_range(0, 4)); j++) cyc();
      ack_pulse();
    end

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
